// File: rtl/bbox_pkg.sv
// Shared constants, state encoding and helpers for the bounding-box scan
// sequencer. Coordinates are unsigned fixed point with FRAC_W fraction bits.
package bbox_pkg;

    localparam int COORD_W = 16;
    localparam int FRAC_W  = 6;

    // One pixel step in fixed point (1.0 = 0x0040)
    localparam logic [COORD_W-1:0] PIX_STEP  = COORD_W'(1) << FRAC_W;
    // Clears the fraction bits so every coordinate sits on a pixel centre grid
    localparam logic [COORD_W-1:0] FRAC_MASK = ~(PIX_STEP - COORD_W'(1));

    // Last visible pixel column/row, used only when scissor clipping is built in
    localparam logic [COORD_W-1:0] SCREEN_X_MAX = 16'h9FC0;
    localparam logic [COORD_W-1:0] SCREEN_Y_MAX = 16'h77C0;

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE,
        LATCH,
        SCAN,
        DONE
    } state_t;

    function automatic logic [COORD_W-1:0] mask_frac(input logic [COORD_W-1:0] v);
        return v & FRAC_MASK;
    endfunction

    function automatic logic [COORD_W-1:0] min_coord(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/raster_walker.sv
// Pixel walker: holds the current x/y position inside the bounding box and
// advances it in raster order on every accepted beat. The end-of-row and
// end-of-box compares use one extra bit so a box touching 0xFFC0 terminates
// instead of wrapping back to zero.
module raster_walker
    import bbox_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic [COORD_W-1:0] xmin,
    input  logic [COORD_W-1:0] xmax,
    input  logic [COORD_W-1:0] ymax,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    logic [COORD_W:0] x_next;
    logic [COORD_W:0] y_next;
    logic             row_end;
    logic             last_row;

    assign x_next   = {1'b0, x} + {1'b0, PIX_STEP};
    assign y_next   = {1'b0, y} + {1'b0, PIX_STEP};
    assign row_end  = x_next > {1'b0, xmax};
    assign last_row = y_next > {1'b0, ymax};
    assign last     = row_end & last_row;

    // Position register: load the top-left corner, then step on each handshake
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // pre-edge values regardless of block ordering in simulation.
        if (!RST_N) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= load_x;
            y <= load_y;
        end else if (step) begin
            if (!row_end) begin
                x <= x_next[COORD_W-1:0];
            end else if (!last_row) begin
                x <= xmin;
                y <= y_next[COORD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bbox_scan_ctrl.sv
// Bounding-box scan sequencer: accepts a triangle, pulses the bbox unit,
// captures the pixel-aligned box after the fixed bbox latency and streams
// every pixel centre in raster order over a valid/ready interface.
// Build option: define SCISSOR_CLIP_EN to clamp the box max corner to the
// visible screen before scanning.
module bbox_scan_ctrl
    import bbox_pkg::*;
#(
    parameter int BB_LATENCY = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               tri_valid,
    output logic               tri_ready,
    output logic               bb_start,
    input  logic [COORD_W-1:0] bb_xmin,
    input  logic [COORD_W-1:0] bb_xmax,
    input  logic [COORD_W-1:0] bb_ymin,
    input  logic [COORD_W-1:0] bb_ymax,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               busy,
    output logic               tri_done
);

    localparam int WAIT_W = (BB_LATENCY < 1) ? 1 : $clog2(BB_LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BB_LATENCY);

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                ready_en_q;
    logic [COORD_W-1:0]  xmin_q;
    logic [COORD_W-1:0]  xmax_q;
    logic [COORD_W-1:0]  ymax_q;

    logic [COORD_W-1:0]  xmin_m;
    logic [COORD_W-1:0]  ymin_m;
    logic [COORD_W-1:0]  xmax_c;
    logic [COORD_W-1:0]  ymax_c;
    logic                box_empty;
    logic                walk_load;
    logic                walk_step;
    logic                walk_last;

    // Pixel-align the incoming corners; the max corner is optionally scissored
    assign xmin_m = mask_frac(bb_xmin);
    assign ymin_m = mask_frac(bb_ymin);
`ifdef SCISSOR_CLIP_EN
    assign xmax_c = min_coord(mask_frac(bb_xmax), SCREEN_X_MAX);
    assign ymax_c = min_coord(mask_frac(bb_ymax), SCREEN_Y_MAX);
`else
    assign xmax_c = mask_frac(bb_xmax);
    assign ymax_c = mask_frac(bb_ymax);
`endif
    assign box_empty = (xmin_m > xmax_c) || (ymin_m > ymax_c);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Holds tri_ready low until the first clock edge after reset release
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    // Bbox latency counter: counts the bb_start cycle plus BB_LATENCY wait cycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                 wait_cnt_q <= '0;
        else if (state_q == COMPUTE) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        else                        wait_cnt_q <= '0;
    end

    // Box capture: the only point where bb_* inputs are observed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
        end else if (state_q == LATCH) begin
            xmin_q <= xmin_m;
            xmax_q <= xmax_c;
            ymax_q <= ymax_c;
        end
    end

    // Next-state and Moore/handshake outputs
    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves a signal unassigned, which would infer a latch.
        state_d   = state_q;
        tri_ready = 1'b0;
        bb_start  = 1'b0;
        pix_valid = 1'b0;
        tri_done  = 1'b0;
        walk_load = 1'b0;
        walk_step = 1'b0;
        case (state_q)
            IDLE: begin
                tri_ready = ready_en_q;
                if (tri_valid && ready_en_q) state_d = COMPUTE;
            end
            COMPUTE: begin
                bb_start = (wait_cnt_q == '0);
                if (wait_cnt_q == WAIT_LAST) state_d = LATCH;
            end
            LATCH: begin
                if (box_empty) begin
                    state_d = DONE;
                end else begin
                    state_d   = SCAN;
                    walk_load = 1'b1;
                end
            end
            SCAN: begin
                pix_valid = 1'b1;
                walk_step = pix_ready;
                if (pix_ready && walk_last) state_d = DONE;
            end
            DONE: begin
                tri_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    raster_walker u_walker (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .load   (walk_load),
        .step   (walk_step),
        .load_x (xmin_m),
        .load_y (ymin_m),
        .xmin   (xmin_q),
        .xmax   (xmax_q),
        .ymax   (ymax_q),
        .x      (pix_x),
        .y      (pix_y),
        .last   (walk_last)
    );

    assign pix_last = (state_q == SCAN) && walk_last;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// Scoreboard bench for bbox_scan_ctrl: expected beats are generated from the
// box corners when a triangle is issued and compared as beats are accepted.
// Scissored expectations are used when SCISSOR_CLIP_EN is defined.
module tb_bbox_scan_ctrl;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        tri_valid;
    logic        tri_ready;
    logic        bb_start;
    logic [15:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_x, pix_y;
    logic        pix_last;
    logic        busy;
    logic        tri_done;

    beat_t exp_q[$];
    int    errors    = 0;
    int    checks    = 0;
    int    beat_cnt  = 0;
    int    start_cnt = 0;
    int    done_cnt  = 0;

    always #5 CLK = ~CLK;

    bbox_scan_ctrl dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .bb_start  (bb_start),
        .bb_xmin   (bb_xmin),
        .bb_xmax   (bb_xmax),
        .bb_ymin   (bb_ymin),
        .bb_ymax   (bb_ymax),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .busy      (busy),
        .tri_done  (tri_done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, between input updates and the handshake edge
    always @(negedge CLK) begin : monitor
        beat_t e;
        if (bb_start) start_cnt++;
        if (tri_done) done_cnt++;
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", {31'b0, pix_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pix_x", {16'b0, pix_x}, {16'b0, e.x});
                check("pix_y", {16'b0, pix_y}, {16'b0, e.y});
                check("pix_last", {31'b0, pix_last}, {31'b0, e.last});
            end
            beat_cnt++;
        end
    end

    // Reference model: pixel-align, optionally scissor, then enumerate in raster order
    task automatic push_box(input logic [15:0] xmin, input logic [15:0] xmax,
                            input logic [15:0] ymin, input logic [15:0] ymax,
                            output int n);
        int    x0, x1, y0, y1;
        beat_t b;
        x0 = int'(xmin) & 'hFFC0;
        x1 = int'(xmax) & 'hFFC0;
        y0 = int'(ymin) & 'hFFC0;
        y1 = int'(ymax) & 'hFFC0;
`ifdef SCISSOR_CLIP_EN
        if (x1 > 'h9FC0) x1 = 'h9FC0;
        if (y1 > 'h77C0) y1 = 'h77C0;
`endif
        n = 0;
        for (int yy = y0; yy <= y1; yy += 64) begin
            for (int xx = x0; xx <= x1; xx += 64) begin
                b.x    = xx[15:0];
                b.y    = yy[15:0];
                b.last = (xx == x1) && (yy == y1);
                exp_q.push_back(b);
                n++;
            end
        end
    endtask

    // Issue one triangle and follow it to completion (or abort it with a reset)
    task automatic run_tri(input logic [15:0] xmin, input logic [15:0] xmax,
                           input logic [15:0] ymin, input logic [15:0] ymax,
                           input int stall_beat, input bit hold_valid,
                           input int abort_beat);
        int nbeats, n, base_beats, base_starts, base_done, stall_cycles;
        bit stalled;
        n = 0;
        while (!tri_ready && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        if (!tri_ready) check("accept_timeout", {31'b0, tri_ready}, 32'd1);

        push_box(xmin, xmax, ymin, ymax, nbeats);
        base_beats  = beat_cnt;
        base_starts = start_cnt;
        base_done   = done_cnt;
        bb_xmin = xmin; bb_xmax = xmax; bb_ymin = ymin; bb_ymax = ymax;
        tri_valid = 1'b1;
        @(posedge CLK); #1;
        if (!hold_valid) tri_valid = 1'b0;
        check("bb_start", {31'b0, bb_start}, 32'd1);
        check("ready_low", {31'b0, tri_ready}, 32'd0);
        check("busy", {31'b0, busy}, 32'd1);

        n = 0;
        while (!pix_valid && !tri_done && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        check("first_latency", n, 32'd3);

        // bb_* must be ignored outside LATCH
        bb_xmin = 16'h0000; bb_xmax = 16'hFFC0; bb_ymin = 16'h0000; bb_ymax = 16'hFFC0;

        stalled      = 1'b0;
        stall_cycles = 0;
        n = 0;
        while (!tri_done && n < 400) begin
            if (abort_beat > 0 && pix_valid && beat_cnt == base_beats + abort_beat - 1) begin
                RST_N = 1'b0;
                #1;
                check("abort_valid", {31'b0, pix_valid}, 32'd0);
                check("abort_busy", {31'b0, busy}, 32'd0);
                check("abort_ready", {31'b0, tri_ready}, 32'd0);
                exp_q.delete();
                repeat (3) begin @(posedge CLK); #1; end
                RST_N = 1'b1;
                repeat (2) begin @(posedge CLK); #1; end
                check("abort_no_done", done_cnt, base_done);
                check("abort_ready_back", {31'b0, tri_ready}, 32'd1);
                tri_valid = 1'b0;
                return;
            end
            if (stall_beat > 0 && !stalled && pix_valid &&
                beat_cnt == base_beats + stall_beat - 1 && exp_q.size() > 0) begin
                pix_ready = 1'b0;
                repeat (5) begin
                    @(posedge CLK); #1; n++;
                    check("stall_valid", {31'b0, pix_valid}, 32'd1);
                    check("stall_x", {16'b0, pix_x}, {16'b0, exp_q[0].x});
                    check("stall_y", {16'b0, pix_y}, {16'b0, exp_q[0].y});
                    check("stall_last", {31'b0, pix_last}, {31'b0, exp_q[0].last});
                end
                pix_ready    = 1'b1;
                stalled      = 1'b1;
                stall_cycles = 5;
            end
            @(posedge CLK); #1; n++;
        end
        if (hold_valid) tri_valid = 1'b0;
        if (!tri_done) check("done_timeout", {31'b0, tri_done}, 32'd1);
        check("scan_cycles", n, nbeats + stall_cycles);
        check("beat_count", beat_cnt - base_beats, nbeats);
        check("queue_empty", exp_q.size(), 32'd0);
        check("start_pulses", start_cnt - base_starts, 32'd1);
        @(posedge CLK); #1;
        check("done_pulse", {31'b0, tri_done}, 32'd0);
        check("done_count", done_cnt - base_done, 32'd1);
        check("ready_back", {31'b0, tri_ready}, 32'd1);
        check("idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST_N     = 1'b0;
        tri_valid = 1'b0;
        pix_ready = 1'b1;
        bb_xmin   = '0; bb_xmax = '0; bb_ymin = '0; bb_ymax = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", {31'b0, tri_ready}, 32'd0);
        check("rst_valid", {31'b0, pix_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_start", {31'b0, bb_start}, 32'd0);
        check("rst_done", {31'b0, tri_done}, 32'd0);
        check("rst_xy", {pix_x, pix_y}, 32'd0);
        check("rst_last", {31'b0, pix_last}, 32'd0);
        RST_N = 1'b1;
        #1;
        check("ready_before_edge", {31'b0, tri_ready}, 32'd0);
        @(posedge CLK); #1;
        check("ready_after_edge", {31'b0, tri_ready}, 32'd1);

        // single pixel
        run_tri(16'h0040, 16'h0040, 16'h0080, 16'h0080, 0, 1'b0, 0);
        // 3x2 box
        run_tri(16'h0000, 16'h0080, 16'h0040, 16'h0080, 0, 1'b0, 0);
        // 3x2 box with 5-cycle backpressure on beat 3
        run_tri(16'h0000, 16'h0080, 16'h0040, 16'h0080, 3, 1'b0, 0);
        // empty box
        run_tri(16'h00C0, 16'h0080, 16'h0000, 16'h0000, 0, 1'b0, 0);
        // tri_valid held through the scan
        run_tri(16'h0000, 16'h0080, 16'h0040, 16'h0080, 0, 1'b1, 0);
        // box at the top of the coordinate range
        run_tri(16'hFF80, 16'hFFC0, 16'h0000, 16'h0000, 0, 1'b0, 0);
        // unaligned corners are snapped to the pixel grid
        run_tri(16'h0045, 16'h00BF, 16'h007F, 16'h007F, 0, 1'b0, 0);
        // reset during beat 2, then a clean triangle
        run_tri(16'h0000, 16'h0080, 16'h0040, 16'h0080, 0, 1'b0, 2);
        run_tri(16'h0000, 16'h0080, 16'h0040, 16'h0080, 0, 1'b0, 0);
        // boxes crossing / beyond the right screen edge
        run_tri(16'h9F80, 16'hA100, 16'h0000, 16'h0000, 0, 1'b0, 0);
        run_tri(16'hA000, 16'hA100, 16'h0000, 16'h0000, 0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bbox_scan_ctrl.md
Name: bbox_scan_ctrl

Overview:
Sequencer for the rasterizer's bounding-box stage. It accepts one triangle at a time and pulses the bbox unit's compute enable. After the fixed bbox latency it captures the rounded min/max corners (unsigned Q10.6). It then walks every pixel centre in the box in raster order, one beat per valid/ready handshake, to the edge-function stage downstream.

Parameters:
COORD_W, 16, coordinate width (unsigned fixed point)
FRAC_W, 6, fractional bits; pixel step = 1<<FRAC_W (0x0040)
BB_LATENCY, 1, cycles from bb_start to valid bbox inputs (>=1)
SCREEN_X_MAX, 16'h9FC0, last pixel column (639) for scissor
SCREEN_Y_MAX, 16'h77C0, last pixel row (479) for scissor

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
tri_valid  in  1  upstream triangle (vertices) valid
tri_ready  out  1  controller can accept a triangle
bb_start  out  1  one-cycle compute enable to bbox unit
bb_xmin  in  COORD_W  rounded bbox x min
bb_xmax  in  COORD_W  rounded bbox x max
bb_ymin  in  COORD_W  rounded bbox y min
bb_ymax  in  COORD_W  rounded bbox y max
pix_valid  out  1  pixel beat valid
pix_ready  in  1  downstream accepts beat
pix_x  out  COORD_W  pixel x (frac bits zero)
pix_y  out  COORD_W  pixel y (frac bits zero)
pix_last  out  1  final beat of triangle
busy  out  1  state != IDLE
tri_done  out  1  one-cycle pulse, triangle fully scanned

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including tri_ready. Internal x/y/bbox/wait registers are 0. tri_ready rises on the first CLK edge after RST_N deasserts.
- States: IDLE -> COMPUTE -> LATCH -> SCAN or DONE -> DONE -> IDLE.
- IDLE: tri_ready=1. When tri_valid&tri_ready is sampled at edge E0, go to COMPUTE. tri_ready=0 from E0 on.
- COMPUTE: bb_start=1 for exactly the first cycle after E0. Wait counter runs BB_LATENCY cycles, then go to LATCH.
- LATCH: one cycle. Register bb_* with low FRAC_W bits forced to 0.
  - Empty box (xmin>xmax or ymin>ymax, unsigned): go to DONE; no beats are emitted.
  - Otherwise: go to SCAN with x=xmin, y=ymin.
- First pix_valid appears BB_LATENCY+2 cycles after E0.
- SCAN: pix_valid=1 and pix_x/pix_y = x/y. Outputs hold stable while pix_ready=0.
- On each handshake:
  - Row end is x+STEP > xmax, computed in COORD_W+1 bits so there is no wrap at 0xFFC0.
  - Not row end: x += STEP.
  - Row end, not last row: x = xmin, y += STEP. Same row-end rule applies in y.
  - Row end and last row: go to DONE.
- pix_last=1 with the final beat only, i.e. the one at (xmax,ymax) after masking.
- DONE: tri_done=1 for one cycle, pix_valid=0, then IDLE. tri_ready returns 1 in the cycle after DONE.
- tri_valid while not IDLE is ignored; there is no queuing.
- Reset mid-operation: immediate return to IDLE. pix_valid and bb_start drop asynchronously; no tri_done is emitted; the partial triangle is lost.
- bb_* are sampled only in LATCH; changes at any other time have no effect.
- Throughput: one beat per cycle with pix_ready held 1. Scanning a WxH box takes W*H cycles plus BB_LATENCY+3 cycles overhead.

Optional Feature:
SCISSOR_CLIP_EN
- Defined: in LATCH, after masking, clamp xmax to min(xmax,SCREEN_X_MAX) and ymax to min(ymax,SCREEN_Y_MAX). The empty test uses the clamped values, so a box fully off-screen yields zero beats.
- Undefined: no clamping; the full box is scanned.

Decomposition:
- Package bbox_pkg: COORD_W, FRAC_W, PIX_STEP, SCREEN_X_MAX/SCREEN_Y_MAX defaults, and a state enum typedef (IDLE, COMPUTE, LATCH, SCAN, DONE).
- One sub-module, raster_walker: holds the x/y registers, load (xmin,ymin), step-on-handshake, the row-end/last compare in COORD_W+1 bits, and pix_last.
- FSM, wait counter and scissor clamp live in bbox_scan_ctrl.

Test Plan:
- Single pixel: bbox (0x0040,0x0040,0x0080,0x0080), pix_ready=1 -> one beat at (0x0040,0x0080) with pix_last=1; tri_done one cycle later; first pix_valid 3 cycles after accept.
- 3x2 box: x 0x0000..0x0080, y 0x0040..0x0080 -> 6 beats (0,40),(40,40),(80,40),(0,80),(40,80),(80,80); pix_last only on the 6th.
- Backpressure: in the 3x2 box, pix_ready=0 for 5 cycles at beat 3 -> pix_x/pix_y/pix_last stable; exactly 6 beats total, no duplicates.
- Empty and edge cases:
  - xmin=0x00C0, xmax=0x0080 -> zero beats; tri_done one cycle after LATCH.
  - tri_valid held during the scan -> not accepted until tri_ready returns.
- Wrap and reset:
  - xmin=0xFF80, xmax=0xFFC0, y=0x0000..0x0000 -> 2 beats, terminates.
  - RST_N pulled low during beat 2 of the 3x2 box -> pix_valid=0 immediately, no tri_done; the next triangle scans cleanly.
- SCISSOR_CLIP_EN:
  - x 0x9F80..0xA100 -> beats at 0x9F80 and 0x9FC0 only.
  - xmin=0xA000 -> zero beats.
